// File: rtl/branch_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_unit_pkg
// Shared encodings for the branch/jump resolution unit. The datapath control
// unit decodes the IR with the same constants, so keep them in one place.
//   - MODE_* : operation selected by the IR opcode
//   - COND_* : IR C2 field condition for conditional branches
//   - state_t: sequencing states of the branch unit
// -----------------------------------------------------------------------------
package branch_unit_pkg;

    localparam logic [1:0] MODE_BR  = 2'b00;
    localparam logic [1:0] MODE_JR  = 2'b01;
    localparam logic [1:0] MODE_JAL = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    localparam logic [1:0] COND_ZERO = 2'b00;
    localparam logic [1:0] COND_NZ   = 2'b01;
    localparam logic [1:0] COND_POS  = 2'b10;
    localparam logic [1:0] COND_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_TARGET = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/branch_unit_con_ff_logic.sv
// -----------------------------------------------------------------------------
// con_ff_logic
// Combinational decode of the C2 condition against a register value. Its
// result is registered into CON by the instantiating unit.
// Ports:
//   cond      in  2       condition select (COND_*)
//   ra_val    in  DATA_W  register value under test
//   cond_true out 1       condition holds for ra_val
// -----------------------------------------------------------------------------
module con_ff_logic
    import branch_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        cond,
    input  logic [DATA_W-1:0] ra_val,
    output logic              cond_true
);

    // Positive means "sign bit clear", so zero counts as positive.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_ZERO: cond_true = (ra_val == '0);
            COND_NZ:   cond_true = (ra_val != '0);
            COND_POS:  cond_true = ~ra_val[DATA_W-1];
            COND_NEG:  cond_true = ra_val[DATA_W-1];
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Multi-cycle branch/jump resolution: IDLE -> EVAL -> TARGET -> COMMIT.
// Evaluates the branch condition into CON, computes the target and issues a
// one-cycle PC load (when taken) and link write (jal) with done in COMMIT.
// Ports:
//   clk, clear_n      clock (rising edge), asynchronous active-low reset
//   start             request, accepted only in IDLE
//   mode, cond        operation and condition select (see package)
//   ra_val, pc, offset operands captured when start is accepted
//   busy, done        busy from the cycle after acceptance through COMMIT;
//                     done pulses in COMMIT
//   con_ff            registered condition result
//   pc_load, pc_next  PC load pulse and target (pc_next holds otherwise)
//   link_we, link_data link-register write pulse and return address
//   taken_cnt, exec_cnt saturating statistics counters
// -----------------------------------------------------------------------------
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 19,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [1:0]        cond,
    input  logic [DATA_W-1:0] ra_val,
    input  logic [DATA_W-1:0] pc,
    input  logic [OFF_W-1:0]  offset,
    output logic              busy,
    output logic              done,
    output logic              con_ff,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_next,
    output logic              link_we,
    output logic [DATA_W-1:0] link_data,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  exec_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state;
    logic [1:0]          mode_q;
    logic [1:0]          cond_q;
    logic [DATA_W-1:0]   ra_q;
    logic [DATA_W-1:0]   pc_q;
    logic [OFF_W-1:0]    off_q;
    logic                cond_true;
    logic                con_next;
    logic [DATA_W-1:0]   target;

    con_ff_logic #(
        .DATA_W(DATA_W)
    ) u_con_ff_logic (
        .cond      (cond_q),
        .ra_val    (ra_q),
        .cond_true (cond_true)
    );

    // CON value for the captured operation: jumps are always taken and the
    // reserved mode behaves as a never-taken branch.
    always_comb begin
        con_next = 1'b0;
        case (mode_q)
            MODE_BR:  con_next = cond_true;
            MODE_JR:  con_next = 1'b1;
            MODE_JAL: con_next = 1'b1;
            default:  con_next = 1'b0;
        endcase
    end

    // Branch target is PC+4 plus the sign-extended C field, wrapping at the
    // datapath width; jumps go to the register value.
    always_comb begin
        target = pc_q + {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};
        if (mode_q == MODE_JR || mode_q == MODE_JAL) begin
            target = ra_q;
        end
    end

    // Sequencer with registered outputs. The commit results are loaded on
    // the edge leaving TARGET so that they are visible during COMMIT; a reset
    // at any point therefore aborts the operation before anything commits.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= ST_IDLE;
            mode_q    <= '0;
            cond_q    <= '0;
            ra_q      <= '0;
            pc_q      <= '0;
            off_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            con_ff    <= 1'b0;
            pc_load   <= 1'b0;
            pc_next   <= '0;
            link_we   <= 1'b0;
            link_data <= '0;
            taken_cnt <= '0;
            exec_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            pc_load <= 1'b0;
            link_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        cond_q <= cond;
                        ra_q   <= ra_val;
                        pc_q   <= pc;
                        off_q  <= offset;
                        busy   <= 1'b1;
                        state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    con_ff <= con_next;
                    state  <= ST_TARGET;
                end
                ST_TARGET: begin
                    done    <= 1'b1;
                    pc_load <= con_ff;
                    if (con_ff) begin
                        pc_next <= target;
                        if (taken_cnt != '1) begin
                            taken_cnt <= taken_cnt + CNT_ONE;
                        end
                    end
                    if (mode_q == MODE_JAL) begin
                        link_we   <= 1'b1;
                        link_data <= pc_q;
                    end
                    if (exec_cnt != '1) begin
                        exec_cnt <= exec_cnt + CNT_ONE;
                    end
                    state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
// Directed bench for branch_unit (CNT_W=2 so saturation is reachable) with a
// cycle-level reference model and hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_branch_unit;
    import branch_unit_pkg::*;

    localparam int DW = 32;
    localparam int OW = 19;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [1:0]    cond = 2'b00;
    logic [DW-1:0] ra_val = '0;
    logic [DW-1:0] pc = '0;
    logic [OW-1:0] offset = '0;
    logic          busy, done, con_ff, pc_load, link_we;
    logic [DW-1:0] pc_next, link_data;
    logic [CW-1:0] taken_cnt, exec_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_seen = 0;
    int load_seen = 0;

    branch_unit #(.DATA_W(DW), .OFF_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .mode(mode), .cond(cond),
        .ra_val(ra_val), .pc(pc), .offset(offset), .busy(busy), .done(done),
        .con_ff(con_ff), .pc_load(pc_load), .pc_next(pc_next), .link_we(link_we),
        .link_data(link_data), .taken_cnt(taken_cnt), .exec_cnt(exec_cnt)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    // Whether an operation transfers control, straight from the ISA rules
    function automatic logic op_taken(input logic [1:0] m, input logic [1:0] c,
                                      input logic [DW-1:0] ra);
        if (m == MODE_JR || m == MODE_JAL) return 1'b1;
        if (m != MODE_BR) return 1'b0;
        case (c)
            COND_ZERO: return ra == 0;
            COND_NZ:   return ra != 0;
            COND_POS:  return ra < 32'h8000_0000;
            default:   return ra >= 32'h8000_0000;
        endcase
    endfunction

    // Target address using signed integer arithmetic modulo 2^32
    function automatic logic [DW-1:0] op_target(input logic [1:0] m, input logic [DW-1:0] ra,
                                                input logic [DW-1:0] p, input logic [OW-1:0] off);
        longint soff;
        longint sum;
        if (m == MODE_JR || m == MODE_JAL) return ra;
        soff = longint'(off);
        if (soff >= 262144) soff = soff - 524288;
        sum = longint'(p) + soff;
        return sum[DW-1:0];
    endfunction

    // Reference model state: expected outputs after each edge
    int            phase = 0;
    logic          m_busy = 0, m_done = 0, m_con = 0, m_load = 0, m_lwe = 0;
    logic [DW-1:0] m_pc_next = '0, m_link = '0;
    int            m_taken = 0, m_exec = 0;
    logic          op_t = 0, op_jal = 0;
    logic [DW-1:0] op_tgt = '0, op_pc = '0;

    // Model: an accepted request resolves two edges later and retires one
    // edge after that; reset discards everything.
    initial forever begin
        @(posedge clk or negedge clear_n);
        if (!clear_n) begin
            phase = 0; m_busy = 0; m_done = 0; m_con = 0; m_load = 0; m_lwe = 0;
            m_pc_next = '0; m_link = '0; m_taken = 0; m_exec = 0;
        end else begin
            case (phase)
                0: if (start) begin
                    op_t   = op_taken(mode, cond, ra_val);
                    op_tgt = op_target(mode, ra_val, pc, offset);
                    op_jal = (mode == MODE_JAL);
                    op_pc  = pc;
                    m_busy = 1; phase = 1;
                end
                1: begin m_con = op_t; phase = 2; end
                2: begin
                    m_done = 1; m_load = op_t; m_lwe = op_jal;
                    if (op_t) m_pc_next = op_tgt;
                    if (op_jal) m_link = op_pc;
                    if (op_t && m_taken < 3) m_taken++;
                    if (m_exec < 3) m_exec++;
                    phase = 3;
                end
                default: begin
                    m_done = 0; m_load = 0; m_lwe = 0; m_busy = 0; phase = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        if (done) done_seen++;
        if (pc_load) load_seen++;
        total_cnt++;
        if (busy === m_busy && done === m_done && con_ff === m_con && pc_load === m_load &&
            link_we === m_lwe && pc_next === m_pc_next && link_data === m_link &&
            taken_cnt === CW'(m_taken) && exec_cnt === CW'(m_exec)) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL cycle_model t=%0t actual b%b d%b c%b l%b w%b pc=%h ln=%h t%0d e%0d required b%b d%b c%b l%b w%b pc=%h ln=%h t%0d e%0d",
                     $time, busy, done, con_ff, pc_load, link_we, pc_next, link_data, taken_cnt, exec_cnt,
                     m_busy, m_done, m_con, m_load, m_lwe, m_pc_next, m_link, m_taken, m_exec);
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic applyReset();
        @(negedge clk);
        clear_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    // Issue one request and return on the negedge where done is high
    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] c, input logic [DW-1:0] ra,
                                 input logic [DW-1:0] p, input logic [OW-1:0] off);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 10) begin @(negedge clk); n++; end
        if (busy) checkOutput("idle_timeout", 32'(busy), 0);
        mode = m; cond = c; ra_val = ra; pc = p; offset = off; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 8) begin @(negedge clk); n++; end
        checkOutput("latency", n, 2);
    endtask

    initial begin
        $display("[TB] branch_unit directed test");
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_con", 32'(con_ff), 0);
        checkOutput("rst_pc_next", pc_next, 0);
        checkOutput("rst_cnt", {taken_cnt, exec_cnt}, 0);
        clear_n = 1'b1;

        applyStimulus(MODE_BR, COND_ZERO, 32'h0, 32'h4, 19'h00023);
        checkOutput("brz_con", 32'(con_ff), 1);
        checkOutput("brz_load", 32'(pc_load), 1);
        checkOutput("brz_target", pc_next, 32'h27);
        checkOutput("brz_cnt", {taken_cnt, exec_cnt}, 32'b0101);

        applyStimulus(MODE_BR, COND_NZ, 32'hFFFF_FFF5, 32'h10, 19'h7FFF6);
        checkOutput("brnz_target", pc_next, 32'h6);
        applyStimulus(MODE_BR, COND_ZERO, 32'hFFFF_FFF5, 32'h10, 19'h7FFF6);
        checkOutput("brnt_con", 32'(con_ff), 0);
        checkOutput("brnt_load", 32'(pc_load), 0);
        checkOutput("brnt_hold", pc_next, 32'h6);
        checkOutput("brnt_cnt", {taken_cnt, exec_cnt}, 32'b1011);

        applyReset();
        applyStimulus(MODE_BR, COND_POS, 32'h8000_0000, 32'h100, 19'h10);
        checkOutput("brpos_con", 32'(con_ff), 0);
        applyStimulus(MODE_BR, COND_NEG, 32'h8000_0000, 32'h100, 19'h10);
        checkOutput("brneg_target", pc_next, 32'h110);
        applyStimulus(MODE_BR, COND_POS, 32'h0, 32'h100, 19'h20);
        checkOutput("brpos0_con", 32'(con_ff), 1);
        applyStimulus(MODE_BR, COND_NEG, 32'h0, 32'h100, 19'h20);
        checkOutput("brneg0_con", 32'(con_ff), 0);

        applyReset();
        applyStimulus(MODE_JAL, COND_ZERO, 32'h100, 32'h24, 19'h5);
        checkOutput("jal_target", pc_next, 32'h100);
        checkOutput("jal_link_we", 32'(link_we), 1);
        checkOutput("jal_link", link_data, 32'h24);
        applyStimulus(MODE_JR, COND_ZERO, 32'h200, 32'h24, 19'h5);
        checkOutput("jr_target", pc_next, 32'h200);
        checkOutput("jr_link_we", 32'(link_we), 0);
        applyStimulus(MODE_RSV, COND_ZERO, 32'h0, 32'h40, 19'h4);
        checkOutput("rsv_load", {31'b0, pc_load}, 0);

        // start held through EVAL, TARGET and COMMIT must yield one operation
        applyReset();
        @(negedge clk);
        done_seen = 0;
        mode = MODE_JR; cond = COND_ZERO; ra_val = 32'h300; pc = 32'h8; offset = '0; start = 1'b1;
        @(negedge clk);
        ra_val = 32'h400; mode = MODE_JAL;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("ignore_done", done_seen, 1);
        checkOutput("ignore_target", pc_next, 32'h300);

        // reset while in TARGET: immediate clear and no load afterwards
        @(negedge clk);
        mode = MODE_JR; ra_val = 32'h500; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        load_seen = 0;
        #1 clear_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_pc_next", pc_next, 0);
        checkOutput("abort_cnt", {taken_cnt, exec_cnt}, 0);
        @(negedge clk);
        clear_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("abort_no_load", load_seen, 0);

        // saturation with 2-bit counters and address wrap-around
        for (int i = 0; i < 5; i++) applyStimulus(MODE_BR, COND_ZERO, 32'h0, 32'h1000, 19'h4);
        checkOutput("sat_cnt", {taken_cnt, exec_cnt}, 32'b1111);
        applyStimulus(MODE_BR, COND_ZERO, 32'h0, 32'hFFFF_FFFC, 19'h8);
        checkOutput("wrap_target", pc_next, 32'h4);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
